// File: rtl/sid_seq_pkg.sv
// Shared opcodes, field slices and FSM state encoding for the SID bus sequencer.
package sid_seq_pkg;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;
  localparam int ADDR_W = 5;

  localparam logic [2:0] OP_WRITE = 3'b000;
  localparam logic [2:0] OP_WAIT  = 3'b001;
  localparam logic [2:0] OP_READ  = 3'b010;
  localparam logic [2:0] OP_SYNC  = 3'b011;

  typedef enum logic [3:0] {
    ST_FETCH = 4'd0,
    ST_DATA  = 4'd1,
    ST_WLO   = 4'd2,
    ST_WHI   = 4'd3,
    ST_WRITE = 4'd4,
    ST_WAIT  = 4'd5,
    ST_SYNC  = 4'd6,
    ST_READ  = 4'd7,
    ST_RESP  = 4'd8
  } state_t;

endpackage

// File: rtl/sid_tick_counter.sv
// Loadable down-counter of clkEn ticks for WAIT commands; load wins over decrement.
module sid_tick_counter #(
  parameter int WAIT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero,
  output logic              last
);

  localparam logic [WAIT_W-1:0] CNT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1'b1);

  logic [WAIT_W-1:0] cnt_r;

  // Tick counter register; saturates at zero so a stray decrement cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == CNT_ZERO);
  assign last = (cnt_r == CNT_ONE);

endmodule

// File: rtl/sid_bus_sequencer.sv
// Byte-stream command decoder issuing timed SID register writes, waits and reads.
// Define SID_SEQ_READBACK_EN to enable READ responses; otherwise READ is a 1-byte NOP.
module sid_bus_sequencer
  import sid_seq_pkg::*;
#(
  parameter int WR_ON_CLKEN = 1,
  parameter int WAIT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic [7:0]  iCmd,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  output logic        oWE,
  output logic [4:0]  oAddr,
  output logic [7:0]  oDataW,
  input  logic [7:0]  iDataR,
  output logic [7:0]  oRdData,
  output logic        oRdValid,
  input  logic        iRdReady,
  output logic        oBusy,
  output logic        oErr
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [7:0]          lo_r;
  logic [7:0]          wr_data_r;
  logic                err_r;
  logic                accept_s;
  logic [2:0]          op_s;
  logic                wr_fire_s;
  logic [15:0]         wait_raw_s;
  logic [WAIT_W-1:0]   wait_val_s;
  logic                wait_zero_s;
  logic                cnt_load_s;
  logic                cnt_dec_s;
  logic                cnt_zero_s;
  logic                cnt_last_s;

  assign oCmdReady = (state_r == ST_FETCH) || (state_r == ST_DATA) ||
                     (state_r == ST_WLO)   || (state_r == ST_WHI);
  assign oBusy     = (state_r != ST_FETCH);
  assign accept_s  = iCmdValid && oCmdReady;
  assign op_s      = iCmd[OP_MSB:OP_LSB];
  // The write strobe must line up with the clkEn that sid samples, so it is not registered.
  assign wr_fire_s = (state_r == ST_WRITE) && ((WR_ON_CLKEN == 0) || clkEn);
  assign oWE       = wr_fire_s;
  assign oAddr     = wr_addr_r;
  assign oDataW    = wr_data_r;
  assign oErr      = err_r;

  assign wait_raw_s = {iCmd, lo_r};
  generate
    if (WAIT_W > 16) begin : g_wait_ext
      assign wait_val_s = {{(WAIT_W-16){1'b0}}, wait_raw_s};
    end else begin : g_wait_trunc
      assign wait_val_s = wait_raw_s[WAIT_W-1:0];
    end
  endgenerate
  assign wait_zero_s = (wait_val_s == {WAIT_W{1'b0}});
  assign cnt_load_s  = (state_r == ST_WHI) && accept_s;
  assign cnt_dec_s   = (state_r == ST_WAIT) && clkEn;

  sid_tick_counter #(
    .WAIT_W (WAIT_W)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (wait_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s),
    .last     (cnt_last_s)
  );

  // Next-state decode of the command FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (accept_s) begin
          case (op_s)
            OP_WRITE: state_nxt_s = ST_DATA;
            OP_WAIT:  state_nxt_s = ST_WLO;
            OP_READ: begin
`ifdef SID_SEQ_READBACK_EN
              state_nxt_s = ST_READ;
`else
              state_nxt_s = ST_FETCH;
`endif
            end
            OP_SYNC:  state_nxt_s = ST_SYNC;
            default:  state_nxt_s = ST_FETCH;
          endcase
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DATA: begin
        if (accept_s) state_nxt_s = ST_WRITE;
        else          state_nxt_s = ST_DATA;
      end
      ST_WLO: begin
        if (accept_s) state_nxt_s = ST_WHI;
        else          state_nxt_s = ST_WLO;
      end
      ST_WHI: begin
        if (accept_s && wait_zero_s) state_nxt_s = ST_FETCH;
        else if (accept_s)           state_nxt_s = ST_WAIT;
        else                         state_nxt_s = ST_WHI;
      end
      ST_WRITE: begin
        if (wr_fire_s) state_nxt_s = ST_FETCH;
        else           state_nxt_s = ST_WRITE;
      end
      ST_WAIT: begin
        if (cnt_zero_s || (clkEn && cnt_last_s)) state_nxt_s = ST_FETCH;
        else                                     state_nxt_s = ST_WAIT;
      end
      ST_SYNC: begin
        if (clkEn) state_nxt_s = ST_FETCH;
        else       state_nxt_s = ST_SYNC;
      end
`ifdef SID_SEQ_READBACK_EN
      ST_READ: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (iRdReady) state_nxt_s = ST_FETCH;
        else          state_nxt_s = ST_RESP;
      end
`else
      ST_READ: state_nxt_s = ST_FETCH;
      ST_RESP: state_nxt_s = ST_FETCH;
`endif
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // FSM state, frame fields and the bus-side output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      addr_r    <= {ADDR_W{1'b0}};
      lo_r      <= 8'h00;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= 8'h00;
      err_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_FETCH) && accept_s) begin
        addr_r <= iCmd[ADDR_W-1:0];
      end
      if ((state_r == ST_FETCH) && accept_s && op_s[2]) begin
        err_r <= 1'b1;
      end
      if ((state_r == ST_WLO) && accept_s) begin
        lo_r <= iCmd;
      end
      // Address and data are presented before WRITE so oWE never sees stale values.
      if ((state_r == ST_DATA) && accept_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= iCmd;
      end
`ifdef SID_SEQ_READBACK_EN
      else if ((state_r == ST_FETCH) && accept_s && (op_s == OP_READ)) begin
        wr_addr_r <= iCmd[ADDR_W-1:0];
      end
`endif
    end
  end

`ifdef SID_SEQ_READBACK_EN
  logic [7:0] rd_data_r;
  logic       rd_valid_r;

  // Read response: capture iDataR at the end of READ and hold it until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
    end else if (state_r == ST_READ) begin
      rd_data_r  <= iDataR;
      rd_valid_r <= 1'b1;
    end else if ((state_r == ST_RESP) && iRdReady) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_valid_r;
    end
  end

  assign oRdData  = rd_data_r;
  assign oRdValid = rd_valid_r;
`else
  logic unused_s;
  assign unused_s = ^{iDataR, iRdReady};
  assign oRdData  = 8'h00;
  assign oRdValid = 1'b0;
`endif

endmodule

// File: tb/tb_sid_bus_sequencer.sv
// Directed bench for sid_bus_sequencer: one instance per write-timing mode, shared clock/clkEn.
module tb_sid_bus_sequencer;

  logic       clk;
  logic       rst;
  logic       clkEn;
  logic [7:0] cmd0, cmd1;
  logic       val0, val1;
  logic       rdy0, rdy1;
  logic       we0, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] dw0, dw1;
  logic [7:0] dr0, dr1;
  logic [7:0] rd0, rd1;
  logic       rv0, rv1;
  logic       rr0, rr1;
  logic       busy0, busy1;
  logic       err0, err1;

  int n_chk;
  int n_err;
  int ce_period;
  int ce_cnt;
  int ce_seen;
  int ce_at_we1;
  int we0_cnt;
  int we1_cnt;
  int snap;
  int n;
  logic last_ce;
  logic we1_ce;

  // Register file model for reads: reg 0x1B holds 0xA5, others echo their address.
  assign dr0 = (addr0 == 5'h1B) ? 8'hA5 : {3'b000, addr0};
  assign dr1 = 8'h00;

  sid_bus_sequencer #(.WR_ON_CLKEN(0), .WAIT_W(16)) dut0 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iCmd(cmd0), .iCmdValid(val0), .oCmdReady(rdy0),
    .oWE(we0), .oAddr(addr0), .oDataW(dw0), .iDataR(dr0), .oRdData(rd0), .oRdValid(rv0),
    .iRdReady(rr0), .oBusy(busy0), .oErr(err0)
  );

  sid_bus_sequencer #(.WR_ON_CLKEN(1), .WAIT_W(16)) dut1 (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iCmd(cmd1), .iCmdValid(val1), .oCmdReady(rdy1),
    .oWE(we1), .oAddr(addr1), .oDataW(dw1), .iDataR(dr1), .oRdData(rd1), .oRdValid(rv1),
    .iRdReady(rr1), .oBusy(busy1), .oErr(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clkEn strobe every ce_period clocks (0 = never), changing well after the rising edge.
  initial begin
    clkEn  = 1'b0;
    ce_cnt = 0;
    forever begin
      @(posedge clk);
      #3;
      ce_cnt = ce_cnt + 1;
      if (ce_period == 0) begin
        clkEn = 1'b0;
      end else if (ce_cnt >= ce_period) begin
        clkEn  = 1'b1;
        ce_cnt = 0;
      end else begin
        clkEn = 1'b0;
      end
    end
  end

  // Mid-cycle monitor of write strobes and clkEn pulses.
  always @(negedge clk) begin
    if (clkEn) ce_seen <= ce_seen + 1;
    last_ce <= clkEn;
    if (we0) we0_cnt <= we0_cnt + 1;
    if (we1) begin
      we1_cnt   <= we1_cnt + 1;
      we1_ce    <= clkEn;
      ce_at_we1 <= ce_seen + (clkEn ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte to instance d and return just after the edge that accepts it.
  task automatic send(input int d, input logic [7:0] b);
    int k;
    k = 0;
    if (d == 0) begin cmd0 = b; val0 = 1'b1; end
    else        begin cmd1 = b; val1 = 1'b1; end
    while ((((d == 0) ? rdy0 : rdy1) !== 1'b1) && (k < 200)) begin
      step();
      k++;
    end
    chk("send_accept_in_time", (k < 200) ? 32'd1 : 32'd0, 32'd1);
    step();
    val0 = 1'b0;
    val1 = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; ce_period = 0; ce_seen = 0; ce_at_we1 = 0;
    we0_cnt = 0; we1_cnt = 0; last_ce = 1'b0; we1_ce = 1'b0;
    rst = 1'b1; cmd0 = 8'h00; cmd1 = 8'h00; val0 = 1'b0; val1 = 1'b0;
    rr0 = 1'b0; rr1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_we",    we0,   1'b0);
    chk("rst_addr",  addr0, 5'h00);
    chk("rst_dataw", dw0,   8'h00);
    chk("rst_rddata", rd0,  8'h00);
    chk("rst_rdvalid", rv0, 1'b0);
    chk("rst_err",   err0,  1'b0);
    chk("rst_busy",  busy0, 1'b0);
    chk("rst_ready", rdy0,  1'b1);
    chk("rst_ready1", rdy1, 1'b1);

    // Immediate write: strobe in the cycle after the data byte, clkEn irrelevant
    snap = we0_cnt;
    send(0, 8'h18);
    chk("wr0_busy_data", busy0, 1'b1);
    send(0, 8'h0F);
    chk("wr0_we",    we0,   1'b1);
    chk("wr0_addr",  addr0, 5'h18);
    chk("wr0_dataw", dw0,   8'h0F);
    chk("wr0_ready_low", rdy0, 1'b0);
    step();
    chk("wr0_we_end",  we0,   1'b0);
    chk("wr0_ready_back", rdy0, 1'b1);
    chk("wr0_addr_hold", addr0, 5'h18);
    step();
    step();
    chk("wr0_one_pulse", we0_cnt - snap, 32'd1);

    // clkEn-aligned write on the second instance
    ce_period = 32;
    repeat (5) step();
    send(1, 8'h04);
    send(1, 8'h41);
    snap = ce_seen;
    n = 0;
    while ((we1_cnt == 0) && (n < 100)) begin step(); n++; end
    chk("wr1_pulse_in_time", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    repeat (40) step();
    chk("wr1_one_pulse", we1_cnt, 32'd1);
    chk("wr1_with_clken", we1_ce, 1'b1);
    chk("wr1_first_clken", ce_at_we1 - snap, 32'd1);
    chk("wr1_addr", addr1, 5'h04);
    chk("wr1_dataw", dw1, 8'h41);

    // WAIT of 3 ticks
    ce_period = 4;
    send(0, 8'h21);
    send(0, 8'h03);
    send(0, 8'h00);
    snap = ce_seen;
    chk("wait_ready_low", rdy0, 1'b0);
    n = 0;
    while ((rdy0 !== 1'b1) && (n < 200)) begin step(); n++; end
    chk("wait_done_in_time", (n < 200) ? 32'd1 : 32'd0, 32'd1);
    chk("wait_ticks", ce_seen - snap, 32'd3);
    chk("wait_exit_on_clken", last_ce, 1'b1);
    chk("wait_busy_off", busy0, 1'b0);

    // WAIT of 0 ticks returns to FETCH straight after the hi byte
    send(0, 8'h20);
    send(0, 8'h00);
    send(0, 8'h00);
    chk("wait0_ready", rdy0, 1'b1);
    chk("wait0_busy", busy0, 1'b0);

    // SYNC holds until the next clkEn
    ce_period = 5;
    send(0, 8'h60);
    chk("sync_busy", busy0, 1'b1);
    n = 0;
    while ((rdy0 !== 1'b1) && (n < 50)) begin step(); n++; end
    chk("sync_done_in_time", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    chk("sync_exit_on_clken", last_ce, 1'b1);
    ce_period = 0;

`ifdef SID_SEQ_READBACK_EN
    // Read of reg 0x1B, response held with the consumer stalled
    send(0, 8'h5B);
    chk("rd_addr", addr0, 5'h1B);
    step();
    chk("rd_valid", rv0, 1'b1);
    chk("rd_data", rd0, 8'hA5);
    cmd0 = 8'hE3;
    val0 = 1'b1;
    repeat (10) step();
    chk("rd_valid_hold", rv0, 1'b1);
    chk("rd_data_hold", rd0, 8'hA5);
    chk("rd_ready_low", rdy0, 1'b0);
    chk("rd_no_accept", err0, 1'b0);
    val0 = 1'b0;
    rr0 = 1'b1;
    step();
    rr0 = 1'b0;
    chk("rd_valid_drop", rv0, 1'b0);
    chk("rd_ready_back", rdy0, 1'b1);
`else
    // READ is a NOP without readback
    send(0, 8'h5B);
    chk("nop_ready", rdy0, 1'b1);
    chk("nop_rdvalid", rv0, 1'b0);
    chk("nop_rddata", rd0, 8'h00);
    chk("nop_err", err0, 1'b0);
    chk("nop_addr_hold", addr0, 5'h18);
`endif

    // Illegal opcode, then a normal write still works
    snap = we0_cnt;
    send(0, 8'hE3);
    chk("ill_err", err0, 1'b1);
    chk("ill_ready", rdy0, 1'b1);
    step();
    step();
    chk("ill_no_we", we0_cnt - snap, 32'd0);
    send(0, 8'h00);
    send(0, 8'h11);
    chk("ill_wr_we", we0, 1'b1);
    chk("ill_wr_addr", addr0, 5'h00);
    chk("ill_wr_dataw", dw0, 8'h11);
    chk("ill_err_sticky", err0, 1'b1);

    // Reset mid-frame: discard the pending write, clear oErr
    send(0, 8'h07);
    snap = we0_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_err", err0, 1'b0);
    chk("mid_rst_we", we0, 1'b0);
    chk("mid_rst_addr", addr0, 5'h00);
    chk("mid_rst_dataw", dw0, 8'h00);
    chk("mid_rst_ready", rdy0, 1'b1);
    send(0, 8'hE0);
    chk("mid_rst_opcode", err0, 1'b1);
    step();
    step();
    chk("mid_rst_no_we", we0_cnt - snap, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
